// File: rtl/afifo_rd_drain_if.sv
// -----------------------------------------------------------------------------
// afifo_rd_drain_if
//
// Bundles the AFIFO read port and the downstream stream used by
// afifo_rd_drain.
//
// Signals:
//   fifo_empty  AFIFO empty flag, synchronous to clk_rd
//   rdata       AFIFO read data, valid on the cycle after rd_en
//   rd_en       AFIFO read strobe
//   out_valid   downstream word available
//   out_data    downstream word
//   out_ready   downstream accepts the word
//   rd_cnt      count of words delivered downstream
//
// Modports:
//   master  the drain block (drives rd_en and the downstream stream)
//   slave   the environment (AFIFO read port plus the downstream consumer)
//
// Handshake: a word moves downstream on every rising clk_rd edge where
// out_valid && out_ready are both high. While out_valid is high and out_ready
// is low, out_data is held stable. out_ready while out_valid is low has no
// effect.
// -----------------------------------------------------------------------------
interface afifo_rd_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_en;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  rd_cnt;

  modport master (
    input  fifo_empty,
    input  rdata,
    input  out_ready,
    output rd_en,
    output out_valid,
    output out_data,
    output rd_cnt
  );

  modport slave (
    output fifo_empty,
    output rdata,
    output out_ready,
    input  rd_en,
    input  out_valid,
    input  out_data,
    input  rd_cnt
  );
endinterface

// File: rtl/afifo_rd_drain.sv
// -----------------------------------------------------------------------------
// afifo_rd_drain
//
// Read-side consumer for an asynchronous FIFO, in the clk_rd domain. Issues
// rd_en, absorbs the FIFO's one-cycle read latency and re-presents the words
// as an in-order valid/ready stream through a 3-entry skid buffer. Reads are
// only issued when the buffer is guaranteed to have room for every word
// already requested, so it sustains one word per cycle with out_ready high
// and never over-reads when out_ready drops.
//
// Ports:
//   clk_rd    read-domain clock
//   rst_rd_n  asynchronous active-low reset
//   bus       afifo_rd_drain_if.master (AFIFO read port + downstream stream)
//
// Optional feature (macro AFIFO_RD_DRAIN_CNT_EN):
//   defined   rd_cnt counts delivered words, wrapping at 2^CNT_WIDTH
//   undefined rd_cnt is tied to 0 and no counter register exists
// -----------------------------------------------------------------------------
module afifo_rd_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd_n,
  afifo_rd_drain_if.master      bus
);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            count;
  logic                  inflight;
  logic [2:0]            occupancy;
  logic                  pop;

  // Circular pointer over three entries: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words held plus the word still on its way from the FIFO; a new read is
  // only allowed if all of them fit, which is what makes out_ready irrelevant
  // to the issue decision.
  assign occupancy = 3'(count) + 3'(inflight);

  // rst_rd_n gates the strobe so no read leaks out while in reset.
  assign bus.rd_en     = rst_rd_n && !bus.fifo_empty && (occupancy < 3'd3);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[head];
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      // Entries are cleared too so out_data reads 0 in reset.
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      if (inflight) begin
        mem[tail] <= bus.rdata;
        tail      <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      // Capture and pop in the same cycle cancel out.
      count <= count + 2'(inflight) - 2'(pop);
    end
  end

`ifdef AFIFO_RD_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.rd_cnt = cnt_q;
`else
  assign bus.rd_cnt = '0;
`endif

endmodule

// File: tb/tb_afifo_rd_drain.sv
// -----------------------------------------------------------------------------
// tb_afifo_rd_drain
//
// Directed bench for afifo_rd_drain. A small AFIFO read-port model (queue,
// one-cycle read latency, empty flag refreshed on the falling edge) feeds the
// DUT; the expected queue holds every word pushed into that model, in order.
// -----------------------------------------------------------------------------
module tb_afifo_rd_drain;
  localparam int DW = 32;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk_rd   = 1'b0;
  logic rst_rd_n = 1'b0;
  always #5 clk_rd = ~clk_rd;

  // ---------------- DUT + interface ----------------
  logic          fifo_empty_m = 1'b1;
  logic [DW-1:0] rdata_m      = '0;
  logic          out_ready_m  = 1'b0;

  afifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  assign bus.fifo_empty = fifo_empty_m;
  assign bus.rdata      = rdata_m;
  assign bus.out_ready  = out_ready_m;

  afifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_rd   (clk_rd),
    .rst_rd_n (rst_rd_n),
    .bus      (bus)
  );

  // ---------------- AFIFO read-port model ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            rd_pulses   = 0;
  int            empty_reads = 0;

  always @(posedge clk_rd) begin
    if (bus.rd_en) begin
      rd_pulses++;
      if (fifo_q.size() == 0) empty_reads++;
      else rdata_m <= fifo_q.pop_front();
    end
  end

  always @(negedge clk_rd) begin
    fifo_empty_m = (fifo_q.size() == 0);
  end

  // ---------------- scoreboard state ----------------
  int            n_cmp     = 0;
  int            n_bad     = 0;
  int            pops_done = 0;
  logic [DW-1:0] exp_w;

  function automatic logic [CW-1:0] cnt_model();
`ifdef AFIFO_RD_DRAIN_CNT_EN
    return CW'(pops_done);
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_rd);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_rd_n    = 1'b0;
    out_ready_m = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h11 + i));
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
      n_cmp++; if (bus.rd_cnt !== '0) begin n_bad++; $display("FAIL reset_rd_cnt: got %0h expected 0", bus.rd_cnt); end
    end
    rst_rd_n = 1'b1;
    #1;
    n_cmp++; if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL first_rd_en: got %b expected 1", bus.rd_en); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_n1: got %b expected 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_n2_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== DW'(32'h11)) begin n_bad++; $display("FAIL latency_n2_data: got %0h expected 11", bus.out_data); end
  endtask

  // Continues straight from test_reset: 2 stalled cycles already elapsed.
  task automatic test_backpressure();
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(32'h11)) begin
        n_bad++; $display("FAIL stall_hold: got valid=%b data=%0h expected valid=1 data=11", bus.out_valid, bus.out_data);
      end
    end
    n_cmp++; if (rd_pulses !== 3) begin n_bad++; $display("FAIL stall_rd_pulses: got %0d expected 3", rd_pulses); end
    out_ready_m = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL bp_rd_cnt: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
      if (bus.out_valid) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (bus.out_data !== exp_w) begin n_bad++; $display("FAIL bp_order: got %0h expected %0h", bus.out_data, exp_w); end
        pops_done++;
      end
      tick();
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL bp_drain: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got valid=%b expected 0", bus.out_valid); end
`ifdef AFIFO_RD_DRAIN_CNT_EN
    n_cmp++; if (bus.rd_cnt !== CW'(8)) begin n_bad++; $display("FAIL bp_rd_cnt_final: got %0d expected 8", bus.rd_cnt); end
`else
    n_cmp++; if (bus.rd_cnt !== '0) begin n_bad++; $display("FAIL bp_rd_cnt_final: got %0d expected 0", bus.rd_cnt); end
`endif
  endtask

  task automatic test_stream();
    int waited;
    out_ready_m = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h11 + i));
    waited = 0;
    while (!bus.out_valid && waited < 10) begin
      n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL stream_idle_cnt: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
      tick();
      waited++;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid: beat %0d got %b expected 1", i, bus.out_valid); end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (bus.out_data !== exp_w) begin n_bad++; $display("FAIL stream_data: beat %0d got %0h expected %0h", i, bus.out_data, exp_w); end
      end
      n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL stream_rd_cnt: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
      if (bus.out_valid) pops_done++;
      tick();
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end: got valid=%b expected 0", bus.out_valid); end
    n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL stream_rd_cnt_final: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 16; i++) push_word(DW'(32'h21 + i));
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      out_ready_m = (c % 2 == 1);
      n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL toggle_rd_cnt: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
      if (bus.out_valid && out_ready_m) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (bus.out_data !== exp_w) begin n_bad++; $display("FAIL toggle_order: got %0h expected %0h", bus.out_data, exp_w); end
        pops_done++;
      end
      tick();
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL toggle_loss: got %0d left expected 0", exp_q.size()); end
    out_ready_m = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL toggle_dup: got valid=%b data=%0h expected valid 0", bus.out_valid, bus.out_data); end
      tick();
    end
    n_cmp++; if (empty_reads !== 0) begin n_bad++; $display("FAIL read_while_empty: got %0d expected 0", empty_reads); end
    n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL toggle_rd_cnt_final: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
  endtask

  task automatic test_reset_mid();
    int base;
    out_ready_m = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 3; i++) push_word(DW'(32'h41 + i));
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_pulses - base >= 3) break;
    end
    // Two words buffered, the third one in flight.
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(32'h41)) begin
      n_bad++; $display("FAIL mid_pre_reset: got valid=%b data=%0h expected valid=1 data=41", bus.out_valid, bus.out_data);
    end
    rst_rd_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_drop: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.rd_cnt !== '0) begin n_bad++; $display("FAIL mid_rd_cnt_reset: got %0d expected 0", bus.rd_cnt); end
    exp_q.delete();
    pops_done = 0;
    tick();
    tick();
    rst_rd_n    = 1'b1;
    out_ready_m = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got valid=%b data=%0h expected valid 0", bus.out_valid, bus.out_data); end
    end
    push_word(DW'(32'h51));
    push_word(DW'(32'h52));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (bus.out_valid) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (bus.out_data !== exp_w) begin n_bad++; $display("FAIL mid_after: got %0h expected %0h", bus.out_data, exp_w); end
        pops_done++;
      end
      tick();
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL mid_drain: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_dup: got valid=%b expected 0", bus.out_valid); end
    n_cmp++; if (bus.rd_cnt !== cnt_model()) begin n_bad++; $display("FAIL mid_rd_cnt: got %0d expected %0d", bus.rd_cnt, cnt_model()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_backpressure();
    test_stream();
    test_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
